operand_mem: RTL and testbench
==============================

# operand_mem

Parametrised multi-port operand memory for the pipelined matrix multiplier. It holds matrix elements and serves NPORT independent read addresses per request through a valid/ready handshake, with a registered, back-pressurable output stage. A single write port loads the memory. An initialisation sequencer sweeps every location after reset before any traffic is accepted. The block sits between the address-generation stage and the multiply-accumulate pipeline.

## Interface
- DATA_W, 8, element width in bits
- ADDR_W, 10, address width
- DEPTH, 1024, number of words; must be ≤ 2**ADDR_W
- NPORT, 4, read addresses served per request
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- req_valid  in  1  read request present
- req_ready  out  1  block can accept a request
- req_addr  in  NPORT*ADDR_W  flattened read addresses; port i in bits [i*ADDR_W +: ADDR_W]
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts out_data
- out_data  out  NPORT*DATA_W  flattened read data; port i in bits [i*DATA_W +: DATA_W]
- init_done  out  1  initialisation sweep complete
- oob_err  out  1  sticky flag: a read or write used an address ≥ DEPTH

## Operation
- FSM states: INIT and RUN. rst forces INIT with init pointer = 0.
- INIT: writes fill value to mem[ptr] each cycle, ptr increments; after writing DEPTH-1 → RUN. wr_en and req_valid are ignored in INIT.
- RUN: req_ready = !out_valid || out_ready. Accept = req_valid && req_ready. On accept, out_data[i] ← mem[req_addr[i]] for each i, and out_valid ← 1.
- If out_valid && out_ready without a new accept, out_valid ← 0. out_data holds its value.
- Holding under back-pressure: while out_valid && !out_ready, out_data and out_valid stay stable. req_ready is 0.
- Write in RUN: wr_en && wr_addr < DEPTH → mem[wr_addr] ← wr_data.
- Same-cycle write and read of one address: the read returns the old data (read-first).
- Out-of-range: a read address ≥ DEPTH returns 0 on that port. A write to an address ≥ DEPTH is dropped. Both cases set oob_err, which is cleared only by rst.
- Duplicate addresses across ports are legal; each such port returns the same word.
- rst mid-operation: a pending output is discarded and the memory is re-swept.

## Timing
- Reset values: out_valid=0, out_data=0, req_ready=0, init_done=0, oob_err=0.
- After rst deasserts: DEPTH cycles of INIT. init_done rises and req_ready may assert on the edge following the last sweep write.
- Read latency: 1 cycle. A request accepted at edge k presents out_data after edge k.
- Throughput: one request per cycle while out_ready=1.

## Configuration
- OPMEM_PRELOAD_EN defined: the INIT sweep writes (index+1) truncated to DATA_W, so mem[0]=1, mem[15]=16. This is the standard test-pattern preload.
- OPMEM_PRELOAD_EN undefined: the INIT sweep writes 0 to every location.
- Sweep duration and all handshake behaviour are identical in both builds.

## Structure
- Shared package operand_mem_pkg holds:
  - state encoding localparams (ST_INIT, ST_RUN)
  - the fill-value function (index → word)
  - default width constants
- Sub-module operand_mem_init_seq contains the INIT counter, fill generation and the init_done flag. The top level instantiates it and muxes its write port with the external write port.

## Test plan
- Reset, DEPTH=16, preload build: init_done rises exactly 16 cycles after rst falls. Request {0,1,2,3} → out_data {1,2,3,4} one cycle later.
- Non-preload build: after init, request {5,5,15,0} → {0,0,0,0}. Then write mem[5]=0xA5 and re-request → port0=port1=0xA5.
- Back-pressure: hold out_ready=0 for 3 cycles after a result. out_data is stable, req_ready=0, and no request is lost. Releasing out_ready gives a back-to-back stream, 1 result per cycle.
- Collision: in the same cycle, write mem[3]=0x7E and read address 3. The result is the old value 4 (preload build); the next read returns 0x7E.
- Out of range, DEPTH=12, ADDR_W=4: read address 13 → port returns 0 and oob_err=1. Write to 14 is dropped. oob_err stays 1 until rst.
- Reset mid-stream: assert rst while out_valid=1 → out_valid=0 next cycle. Earlier writes are overwritten by the re-sweep.

Source files
------------

// File: rtl/operand_mem_pkg.sv
// ----------------------------------------------------------------------------
// operand_mem_pkg
//   Shared declarations for the operand memory slice:
//     - default width/geometry constants
//     - FSM state encoding (ST_INIT, ST_RUN)
//     - fill_word(): the value the initialisation sweep writes to each index
//   Build option:
//     OPMEM_PRELOAD_EN  defined   -> sweep writes (index + 1) truncated to DATA_W
//                       undefined -> sweep writes 0 everywhere
// ----------------------------------------------------------------------------
package operand_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_NPORT  = 4;

    // Two-state controller: sweep the array, then serve traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef OPMEM_PRELOAD_EN
    localparam bit PRELOAD_ON = 1'b1;
`else
    localparam bit PRELOAD_ON = 1'b0;
`endif

    // Fill value for location idx. Returned at 32 bits; callers size-cast
    // to their element width, which gives the required truncation.
    function automatic logic [31:0] fill_word(input logic [31:0] idx);
        return PRELOAD_ON ? (idx + 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/operand_mem_if.sv
// ----------------------------------------------------------------------------
// operand_mem_if
//   Bundles the write port, the request channel and the result channel of
//   operand_mem.
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid && ready are both 1. The producer holds valid and its
//   payload until that edge; ready may depend combinationally on the
//   consumer's own ready (req_ready = !out_valid || out_ready), never on
//   valid. While valid && !ready, the payload does not change.
//
//   Signals:
//     wr_en / wr_addr / wr_data  single write port (master -> memory)
//     req_valid / req_addr       read request, NPORT flattened addresses
//     req_ready                  memory can take a request
//     out_valid / out_data       registered result, NPORT flattened words
//     out_ready                  consumer takes the result
//   Modports: master (address generator / loader side), slave (memory).
// ----------------------------------------------------------------------------
interface operand_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int NPORT  = 4
) ();

    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    logic                      req_valid;
    logic                      req_ready;
    logic [NPORT*ADDR_W-1:0]   req_addr;

    logic                      out_valid;
    logic                      out_ready;
    logic [NPORT*DATA_W-1:0]   out_data;

    modport master (
        output wr_en, wr_addr, wr_data,
        output req_valid, req_addr,
        input  req_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  req_valid, req_addr,
        output req_ready,
        output out_valid, out_data,
        input  out_ready
    );

endinterface

// File: rtl/operand_mem_init_seq.sv
// ----------------------------------------------------------------------------
// operand_mem_init_seq
//   Initialisation sequencer. After rst it walks a pointer from 0 to DEPTH-1,
//   offering one fill write per cycle, then moves to ST_RUN and raises
//   init_done on the same edge that performs the last sweep write.
//   Fill value comes from operand_mem_pkg::fill_word (see OPMEM_PRELOAD_EN).
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     state         current FSM state (observable for checkers)
//     sweep_we      sweep write strobe (high throughout ST_INIT)
//     sweep_addr    location being filled
//     sweep_data    fill value for sweep_addr
//     init_done     registered, high once the sweep has finished
// ----------------------------------------------------------------------------
module operand_mem_init_seq
    import operand_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output state_t            state,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic [DATA_W-1:0] sweep_data,
    output logic              init_done
);

    logic [ADDR_W-1:0] ptr;
    logic              last_ptr;

    assign last_ptr = (32'(ptr) == 32'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            ptr       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (last_ptr) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= ST_INIT;
                    ptr       <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_we   = (state == ST_INIT);
    assign sweep_addr = ptr;
    assign sweep_data = DATA_W'(fill_word(32'(ptr)));

endmodule

// File: rtl/operand_mem.sv
// ----------------------------------------------------------------------------
// operand_mem
//   Multi-port operand memory for the matrix-multiplier pipeline. Serves
//   NPORT independent read addresses per request with one cycle of latency
//   into a registered, back-pressurable output stage. One write port loads
//   the array. After rst an initialisation sweep (operand_mem_init_seq)
//   writes every location before any request or write is honoured.
//
//   Build option: OPMEM_PRELOAD_EN selects the sweep fill pattern
//   (index + 1 when defined, zero otherwise); timing is identical.
//
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     bus        operand_mem_if.slave: write port, request and result channels
//     init_done  sweep complete, memory is serving traffic
//     oob_err    sticky: some read or write used an address >= DEPTH;
//                cleared only by rst
// ----------------------------------------------------------------------------
module operand_mem
    import operand_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NPORT  = DEF_NPORT
) (
    input  logic         clk,
    input  logic         rst,
    operand_mem_if.slave bus,
    output logic         init_done,
    output logic         oob_err
);

    // Bits needed to index the array; the remaining address bits only
    // matter for the out-of-range test.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state;
    logic                run;
    logic                sweep_we;
    logic [ADDR_W-1:0]   sweep_addr;
    logic [DATA_W-1:0]   sweep_data;

    logic                    accept;
    logic                    wr_oob;
    logic                    rd_any_oob;
    logic [NPORT*DATA_W-1:0] rd_flat;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    operand_mem_init_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .sweep_data (sweep_data),
        .init_done  (init_done)
    );

    assign run = (state == ST_RUN);

    // Output slot is free when empty or being drained this cycle.
    assign bus.req_ready = run && (!bus.out_valid || bus.out_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Combinational array read; captured into out_data on accept. Because the
    // array write lands on the same edge, a colliding write is seen only by
    // later requests (read-first).
    always_comb begin
        rd_flat    = '0;
        rd_any_oob = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            logic [ADDR_W-1:0] a;
            a = bus.req_addr[i*ADDR_W +: ADDR_W];
            if (32'(a) >= 32'(DEPTH)) begin
                rd_any_oob = 1'b1;
            end else begin
                rd_flat[i*DATA_W +: DATA_W] = mem[a[IDX_W-1:0]];
            end
        end
    end

    // Write-port mux: the sweep owns the array in ST_INIT, the external
    // port (in-range only) in ST_RUN.
    assign wr_oob    = (32'(bus.wr_addr) >= 32'(DEPTH));
    assign mem_we    = run ? (bus.wr_en && !wr_oob) : sweep_we;
    assign mem_waddr = run ? bus.wr_addr : sweep_addr;
    assign mem_wdata = run ? bus.wr_data : sweep_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
        end
    end

    // Result stage. out_data keeps its last value after being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= rd_flat;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else if (run && ((accept && rd_any_oob) || (bus.wr_en && wr_oob))) begin
            oob_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_mem.sv
// ----------------------------------------------------------------------------
// tb_operand_mem
//   Self-checking bench for operand_mem with DEPTH=12, ADDR_W=4 so that
//   addresses 12..15 are out of range. Expected read results are computed
//   from a reference array at the moment a request is accepted, pushed to
//   exp_q, and compared when the result is consumed. Works in both the
//   default and the OPMEM_PRELOAD_EN builds.
// ----------------------------------------------------------------------------
module tb_operand_mem;
    import operand_mem_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int NPORT  = 4;
    localparam int PW     = NPORT * DATA_W;
    localparam int AW     = NPORT * ADDR_W;

    logic clk;
    logic rst;
    logic init_done;
    logic oob_err;

    operand_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPORT(NPORT)) bus ();

    operand_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NPORT  (NPORT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .oob_err   (oob_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model / scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [PW-1:0]     exp_q[$];
    logic              exp_oob;
    logic              model_run;

    function automatic logic [DATA_W-1:0] model_fill(input int idx);
`ifdef OPMEM_PRELOAD_EN
        return DATA_W'(idx + 1);
`else
        return DATA_W'(0);
`endif
    endfunction

    function automatic logic [PW-1:0] model_read(input logic [AW-1:0] addrs);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < NPORT; i++) begin
            logic [ADDR_W-1:0] a;
            a = addrs[i*ADDR_W +: ADDR_W];
            if (int'(a) < DEPTH) r[i*DATA_W +: DATA_W] = ref_mem[a];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] pack_addr(input int a0, input int a1,
                                                input int a2, input int a3);
        return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    task automatic model_sweep();
        for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = model_fill(i);
        exp_oob = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle. Handshakes are observed at the falling edge (inputs
    // and req_ready are settled), the model is updated, then the bench moves
    // to 1 time unit past the rising edge, where inputs are driven next.
    task automatic step();
        logic [PW-1:0] exp;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, no result pending", bus.out_data);
            end else begin
                exp = exp_q.pop_front();
                if (bus.out_data !== exp) begin
                    errors++;
                    $display("FAIL out_data: got %h expected %h", bus.out_data, exp);
                end
            end
        end
        if (model_run && bus.req_valid && bus.req_ready) begin
            exp_q.push_back(model_read(bus.req_addr));
            for (int i = 0; i < NPORT; i++)
                if (int'(bus.req_addr[i*ADDR_W +: ADDR_W]) >= DEPTH) exp_oob = 1'b1;
        end
        if (model_run && bus.wr_en) begin
            if (int'(bus.wr_addr) < DEPTH) ref_mem[bus.wr_addr] = bus.wr_data;
            else exp_oob = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drain(input string name);
        idle_inputs();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results still pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < DEPTH + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != DEPTH || init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_init_cycles: init_done after %0d cycles (level %b), expected %0d",
                     name, n, init_done, DEPTH);
        end
        model_run = 1'b1;
    endtask

    task automatic request(input logic [AW-1:0] addrs);
        bus.req_valid = 1'b1;
        bus.req_addr  = addrs;
        step();
        bus.req_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_run = 1'b0;
        model_sweep();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.req_ready !== 1'b0 ||
            init_done !== 1'b0 || oob_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ov=%b od=%h rr=%b id=%b oob=%b, expected all 0",
                     bus.out_valid, bus.out_data, bus.req_ready, init_done, oob_err);
        end
        rst = 1'b0;
        wait_init("reset");
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_init: req_ready=%b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_fill();
        request(pack_addr(0, 1, 2, 3));
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_latency: out_valid=%b one cycle after accept, expected 1", bus.out_valid);
        end
        request(pack_addr(5, 5, 11, 0));
        drain("fill");
    endtask

    task automatic test_write();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd5;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        request(pack_addr(5, 5, 2, 7));
        drain("write");
    endtask

    task automatic test_back_to_back();
        request(pack_addr(1, 2, 3, 4));
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = pack_addr(6, 7, 8, 9);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL backpressure_hold: rr=%b ov=%b od=%h, expected rr=0 ov=1 od=%h",
                         bus.req_ready, bus.out_valid, bus.out_data, exp_q[0]);
            end
            step();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.req_addr = pack_addr(c, c + 4, 11 - c, 3);
            step();
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_rate: out_valid=%b in stream cycle %0d, expected 1", bus.out_valid, c);
            end
        end
        drain("back_to_back");
    endtask

    task automatic test_collision();
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 4'd3;
        bus.wr_data   = 8'h7E;
        bus.req_valid = 1'b1;
        bus.req_addr  = pack_addr(3, 3, 0, 3);
        step();
        idle_inputs();
        request(pack_addr(3, 1, 3, 2));
        drain("collision");
    endtask

    task automatic test_oob();
        checks++;
        if (oob_err !== 1'b0) begin
            errors++;
            $display("FAIL oob_clear: oob_err=%b expected 0", oob_err);
        end
        request(pack_addr(13, 1, 12, 15));
        drain("oob_read");
        checks++;
        if (oob_err !== exp_oob) begin
            errors++;
            $display("FAIL oob_set: oob_err=%b expected %b", oob_err, exp_oob);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd14;
        bus.wr_data = 8'hFF;
        step();
        bus.wr_en = 1'b0;
        request(pack_addr(0, 2, 10, 11));
        request(pack_addr(14, 4, 6, 8));
        drain("oob_write");
        checks++;
        if (oob_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_sticky: oob_err=%b expected 1", oob_err);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_addr  = pack_addr($urandom_range(0, 13), $urandom_range(0, 11),
                                      $urandom_range(0, 11), $urandom_range(0, 12));
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_addr   = ADDR_W'($urandom_range(0, 12));
            bus.wr_data   = DATA_W'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain("random");
        checks++;
        if (oob_err !== exp_oob) begin
            errors++;
            $display("FAIL random_oob: oob_err=%b expected %b", oob_err, exp_oob);
        end
    endtask

    task automatic test_reset_mid();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.wr_data = 8'h55;
        step();
        bus.wr_en = 1'b0;
        request(pack_addr(1, 1, 1, 1));
        bus.out_ready = 1'b0;
        rst = 1'b1;
        model_run = 1'b0;
        @(posedge clk);
        #1;
        model_sweep();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || init_done !== 1'b0 ||
            oob_err !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ov=%b od=%h id=%b oob=%b rr=%b, expected all 0",
                     bus.out_valid, bus.out_data, init_done, oob_err, bus.req_ready);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        wait_init("reset_mid");
        request(pack_addr(1, 2, 3, 5));
        request(pack_addr(0, 11, 7, 1));
        drain("reset_mid");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.req_addr = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        test_reset();
        test_fill();
        test_write();
        test_back_to_back();
        test_collision();
        test_oob();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
